// File: rtl/dqn_fp32_pkg.sv
// Shared fp32 datapath definitions: word width and the serializer state encoding.
package dqn_fp32_pkg;

  localparam int FP32_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/vector_serializer_floating_point32.sv
// Serializes a packed vector of fp32 words into a word stream, with one pending
// vector slot so that back-to-back vectors stream at one word per clock.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ACTIVE slot empty; o_valid low, o_data holds its last value
// SEND    | ACTIVE slot holds a vector; word idx is presented on o_data
module vector_serializer_floating_point32
  import dqn_fp32_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH,
  parameter int NUM_WORDS  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] i_data,
  output logic                            o_ready,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_last,
  input  logic                            i_ready
);

  localparam int            IW       = $clog2(NUM_WORDS);
  localparam int            VW       = NUM_WORDS * DATA_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  ser_state_e state, state_nxt;

  logic [VW-1:0]         active_q;
  logic [VW-1:0]         pend_q;
  logic                  pend_full;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] word_nxt;

  logic accept, xfer, at_last;
  logic load_in_active, load_pend_active, load_pend, advance;

  assign o_ready = !pend_full;
  assign o_valid = (state == ST_SEND);
  assign o_last  = o_valid && at_last;
  assign o_data  = data_q;

  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid && i_ready;
  assign at_last = (idx == LAST_IDX);
  assign idx_nxt = idx + IW'(1);

  // o_data is registered so it can hold its last value through IDLE
  always_comb begin
    word_nxt = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx_nxt == IW'(k)) word_nxt = active_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt        = state;
    load_in_active   = 1'b0;
    load_pend_active = 1'b0;
    load_pend        = 1'b0;
    advance          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_in_active = 1'b1;
          state_nxt      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer && !at_last) advance = 1'b1;
        if (xfer && at_last) begin
          if (pend_full)   load_pend_active = 1'b1;
          else if (accept) load_in_active   = 1'b1;
          else             state_nxt        = ST_IDLE;
        end
        // accept only happens with PENDING empty, so it never collides with a PENDING move
        if (accept && !load_in_active) load_pend = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= '0;
      pend_q    <= '0;
      pend_full <= 1'b0;
      idx       <= '0;
      data_q    <= '0;
    end else begin
      if (load_in_active) begin
        active_q <= i_data;
        idx      <= '0;
        data_q   <= i_data[DATA_WIDTH-1:0];
      end else if (load_pend_active) begin
        active_q  <= pend_q;
        idx       <= '0;
        data_q    <= pend_q[DATA_WIDTH-1:0];
        pend_full <= 1'b0;
      end else if (advance) begin
        idx    <= idx_nxt;
        data_q <= word_nxt;
      end
      if (load_pend) begin
        pend_q    <= i_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vector_serializer_floating_point32.md
VECTOR_SERIALIZER_FLOATING_POINT32 -- requirements
Module: vector_serializer_floating_point32

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one IEEE-754 single-precision word.
REQ-002 Parameter NUM_WORDS, default 3: words per input vector; legal range 2..16.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  the input vector on i_data is valid.
REQ-007 i_data  input  NUM_WORDS*DATA_WIDTH  packed vector; word k = i_data[k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 o_ready  output  1  block can accept a vector this cycle.
REQ-009 o_valid  output  1  o_data holds a valid word.
REQ-010 o_data  output  DATA_WIDTH  current serialized word.
REQ-011 o_last  output  1  the current word is word NUM_WORDS-1 of its vector.
REQ-012 i_ready  input  1  downstream accepts o_data this cycle.

Function
REQ-013 An input vector SHALL be accepted on a rising edge where i_valid && o_ready; i_valid SHALL be ignored while o_ready is low.
REQ-014 A word SHALL transfer on a rising edge where o_valid && i_ready.
REQ-015 Storage SHALL be two vector slots: ACTIVE (being sent) and PENDING (next vector).
REQ-016 FSM states: IDLE (ACTIVE empty) and SEND (ACTIVE holds a vector).
REQ-017 IDLE -> SEND on accept: the vector loads into ACTIVE, the word index is 0, and word 0 appears on o_data with o_valid=1 the next cycle; latency is 1 clock.
REQ-018 In SEND, an accept SHALL load PENDING; o_ready = PENDING empty.
REQ-019 Words SHALL be emitted in order 0..NUM_WORDS-1; the index increments only on a transfer.
REQ-020 While o_valid && !i_ready, o_data, o_last and o_valid SHALL hold stable.
REQ-021 o_last SHALL be 1 exactly when index = NUM_WORDS-1 and o_valid=1.
REQ-022 On transfer of the last word: if PENDING is full, PENDING moves to ACTIVE, the index goes to 0, and the state stays SEND with no bubble; if PENDING is empty, the state goes to IDLE.
REQ-023 Simultaneous last-word transfer and accept (PENDING empty) SHALL load the new vector directly into ACTIVE with no bubble; sustained throughput is 1 word/clock.
REQ-024 Simultaneous last-word transfer and a PENDING-to-ACTIVE move SHALL free PENDING, and o_ready SHALL rise the next cycle.
REQ-025 In IDLE, o_valid=0 and o_last=0; o_data holds its last value.
REQ-026 Word values SHALL pass through bit-exact, with no floating-point interpretation.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state=IDLE, both slots empty, index=0, o_valid=0, o_last=0, o_data=0, o_ready=1 after release.
REQ-028 Reset mid-vector SHALL discard ACTIVE and PENDING contents; no partial vector resumes after release.

Structure
REQ-029 DATA_WIDTH default and the state encoding (IDLE, SEND) SHALL live in the shared package dqn_fp32_pkg.
REQ-030 The index width SHALL be $clog2(NUM_WORDS).
REQ-031 No sub-module is required; the word-select mux stays inline.

Verification
REQ-032 Single vector {0x3F800000, 0x40000000, 0x40400000} with i_ready=1 SHALL produce o_data 0x3F800000, 0x40000000, 0x40400000 on cycles +1..+3, o_last only on cycle +3, then IDLE.
REQ-033 Two vectors A and B presented back-to-back with i_ready=1 SHALL produce 6 consecutive valid words A0..A2, B0..B2 with no bubble; o_ready drops for exactly the cycles PENDING is full.
REQ-034 Holding i_ready=0 for 4 cycles on word 1 SHALL keep o_data=word1 and o_valid=1 constant; word 2 follows the cycle after i_ready=1.
REQ-035 With PENDING full and ACTIVE stalled, asserting i_valid with vector C SHALL be ignored: C is never emitted and o_ready=0.
REQ-036 Asserting rst during word 1 of vector A with B pending SHALL produce o_valid=0 and o_data=0 immediately; after release, vector D SHALL emit D0 first, with no A or B word emitted.
REQ-037 With NUM_WORDS=2 and random i_valid/i_ready at 50% for 10k cycles, the output stream SHALL equal the concatenated accepted vectors, with o_last on every second word.
